// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Arbitrates the memory port between D-cache, I-cache and
//            I-prefetcher; tracks tag ownership and throttles prefetch.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int NTAG         = 16,
    parameter int PF_MAX_OUT   = 4,
    parameter int STARVE_LIMIT = 8,
    localparam int TAG_W       = $clog2(NTAG),
    localparam int OUT_W       = $clog2(PF_MAX_OUT + 1)
) (
    input  logic               clock,
    input  logic               reset,

    input  logic [1:0]         dc_command,
    input  logic [XLEN-1:0]    dc_addr,
    input  logic [63:0]        dc_data,
    input  logic [1:0]         ic_command,
    input  logic [XLEN-1:0]    ic_addr,
    input  logic [1:0]         pf_command,
    input  logic [XLEN-1:0]    pf_addr,

    input  logic [TAG_W-1:0]   mem2arb_response,
    input  logic [TAG_W-1:0]   mem2arb_tag,

    output logic [1:0]         arb2mem_command,
    output logic [XLEN-1:0]    arb2mem_addr,
    output logic [63:0]        arb2mem_data,

    output logic [TAG_W-1:0]   dc_response,
    output logic [TAG_W-1:0]   ic_response,
    output logic [TAG_W-1:0]   pf_response,
    output logic [TAG_W-1:0]   dc_tag,
    output logic [TAG_W-1:0]   ic_tag,
    output logic [TAG_W-1:0]   pf_tag,

    output logic               pf_give_way,
    output logic [OUT_W-1:0]   pf_outstanding,
    output logic               tag_error
);

    localparam int STV_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] c_bus_none  = 2'd0;
    localparam logic [1:0] c_bus_load  = 2'd1;

    // Requester ids double as ownership-table entries.
    localparam logic [1:0] c_own_none  = 2'd0;
    localparam logic [1:0] c_own_dc    = 2'd1;
    localparam logic [1:0] c_own_ic    = 2'd2;
    localparam logic [1:0] c_own_pf    = 2'd3;

    localparam logic [OUT_W-1:0] c_pf_max     = OUT_W'(PF_MAX_OUT);
    localparam logic [STV_W-1:0] c_starve_lim = STV_W'(STARVE_LIMIT);

    logic [1:0]         r_owner [NTAG];
    logic [OUT_W-1:0]   r_pf_out;
    logic [STV_W-1:0]   r_starve;
    logic               r_tag_error;

    logic               w_dc_req;
    logic               w_ic_req;
    logic               w_pf_req;
    logic               w_pf_eligible;
    logic               w_override;
    logic [1:0]         w_grant;
    logic               w_accept;
    logic               w_load_accept;
    logic               w_pf_accept;
    logic               w_ret_valid;
    logic [1:0]         w_ret_owner;
    logic               w_ret_hit;
    logic               w_ret_orphan;
    logic               w_pf_inc;
    logic               w_pf_dec;

    assign w_dc_req      = (dc_command != c_bus_none);
    assign w_ic_req      = (ic_command != c_bus_none);
    assign w_pf_req      = (pf_command != c_bus_none);
    assign w_pf_eligible = w_pf_req && (r_pf_out < c_pf_max);
    assign w_override    = (r_starve == c_starve_lim) && !w_dc_req;

    // DC > IC > PF, except a starved prefetch jumps ahead of IC for one grant.
    always_comb begin
        w_grant = c_own_none;
        if (w_dc_req) begin
            w_grant = c_own_dc;
        end else if (w_override && w_pf_eligible) begin
            w_grant = c_own_pf;
        end else if (w_ic_req) begin
            w_grant = c_own_ic;
        end else if (w_pf_eligible) begin
            w_grant = c_own_pf;
        end
    end

    always_comb begin
        arb2mem_command = c_bus_none;
        arb2mem_addr    = '0;
        arb2mem_data    = '0;
        dc_response     = '0;
        ic_response     = '0;
        pf_response     = '0;
        case (w_grant)
            c_own_dc: begin
                arb2mem_command = dc_command;
                arb2mem_addr    = dc_addr;
                arb2mem_data    = dc_data;
                dc_response     = mem2arb_response;
            end
            c_own_ic: begin
                arb2mem_command = ic_command;
                arb2mem_addr    = ic_addr;
                ic_response     = mem2arb_response;
            end
            c_own_pf: begin
                arb2mem_command = pf_command;
                arb2mem_addr    = pf_addr;
                pf_response     = mem2arb_response;
            end
            default: begin
            end
        endcase
    end

    assign w_accept      = (w_grant != c_own_none) && (mem2arb_response != '0);
    assign w_load_accept = w_accept && (arb2mem_command == c_bus_load);
    assign w_pf_accept   = w_accept && (w_grant == c_own_pf);

    assign pf_give_way   = w_pf_req && ((w_grant != c_own_pf) || (mem2arb_response == '0));

    // Return routing always uses the owner recorded before this edge.
    assign w_ret_valid   = (mem2arb_tag != '0);
    assign w_ret_owner   = r_owner[mem2arb_tag];
    assign w_ret_hit     = w_ret_valid && (w_ret_owner != c_own_none);
    assign w_ret_orphan  = w_ret_valid && (w_ret_owner == c_own_none);

    assign dc_tag = (w_ret_hit && (w_ret_owner == c_own_dc)) ? mem2arb_tag : '0;
    assign ic_tag = (w_ret_hit && (w_ret_owner == c_own_ic)) ? mem2arb_tag : '0;
    assign pf_tag = (w_ret_hit && (w_ret_owner == c_own_pf)) ? mem2arb_tag : '0;

    // A same-tag allocate and clear resolve in favour of the allocate.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NTAG; i++) begin
            if (reset) begin
                r_owner[i] <= c_own_none;
            end else if (w_load_accept && (mem2arb_response == TAG_W'(i))) begin
                r_owner[i] <= w_grant;
            end else if (w_ret_hit && (mem2arb_tag == TAG_W'(i))) begin
                r_owner[i] <= c_own_none;
            end
        end
    end

    assign w_pf_inc = w_load_accept && (w_grant == c_own_pf);
    assign w_pf_dec = w_ret_hit && (w_ret_owner == c_own_pf);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pf_out <= '0;
        end else if (w_pf_inc && !w_pf_dec && (r_pf_out < c_pf_max)) begin
            r_pf_out <= r_pf_out + OUT_W'(1);
        end else if (w_pf_dec && !w_pf_inc && (r_pf_out != '0)) begin
            r_pf_out <= r_pf_out - OUT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_starve <= '0;
        end else if (!w_pf_req || w_pf_accept) begin
            r_starve <= '0;
        end else if (pf_give_way && w_pf_eligible && (r_starve != c_starve_lim)) begin
            r_starve <= r_starve + STV_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag_error <= 1'b0;
        end else if (w_ret_orphan) begin
            r_tag_error <= 1'b1;
        end
    end

    assign pf_outstanding = r_pf_out;
    assign tag_error      = r_tag_error;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Self-checking bench: vector table, directed corner sequences and
//            randomized traffic against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int XLEN = 32;
    localparam logic [1:0] c_none  = 2'd0;
    localparam logic [1:0] c_load  = 2'd1;
    localparam logic [1:0] c_store = 2'd2;
    localparam logic [XLEN-1:0] c_dc_addr = 32'h1000_0040;
    localparam logic [XLEN-1:0] c_ic_addr = 32'h2000_0080;
    localparam logic [XLEN-1:0] c_pf_addr = 32'h3000_00c0;
    localparam logic [63:0]     c_dc_data = 64'hdead_beef_0123_4567;

    logic            clock = 1'b0;
    logic            reset;
    logic [1:0]      dc_command, ic_command, pf_command;
    logic [XLEN-1:0] dc_addr, ic_addr, pf_addr;
    logic [63:0]     dc_data;
    logic [3:0]      mem2arb_response, mem2arb_tag;
    logic [1:0]      arb2mem_command;
    logic [XLEN-1:0] arb2mem_addr;
    logic [63:0]     arb2mem_data;
    logic [3:0]      dc_response, ic_response, pf_response;
    logic [3:0]      dc_tag, ic_tag, pf_tag;
    logic            pf_give_way;
    logic [2:0]      pf_outstanding;
    logic            tag_error;

    always #5 clock = ~clock;

    mem_bus_arbiter #(.XLEN(XLEN), .NTAG(16), .PF_MAX_OUT(4), .STARVE_LIMIT(8)) dut (
        .clock(clock), .reset(reset),
        .dc_command(dc_command), .dc_addr(dc_addr), .dc_data(dc_data),
        .ic_command(ic_command), .ic_addr(ic_addr),
        .pf_command(pf_command), .pf_addr(pf_addr),
        .mem2arb_response(mem2arb_response), .mem2arb_tag(mem2arb_tag),
        .arb2mem_command(arb2mem_command), .arb2mem_addr(arb2mem_addr),
        .arb2mem_data(arb2mem_data),
        .dc_response(dc_response), .ic_response(ic_response), .pf_response(pf_response),
        .dc_tag(dc_tag), .ic_tag(ic_tag), .pf_tag(pf_tag),
        .pf_give_way(pf_give_way), .pf_outstanding(pf_outstanding), .tag_error(tag_error)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] dcc, input logic [1:0] icc, input logic [1:0] pfc,
                         input logic [3:0] resp, input logic [3:0] rtag);
        dc_command = dcc; ic_command = icc; pf_command = pfc;
        mem2arb_response = resp; mem2arb_tag = rtag;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(c_none, c_none, c_none, 4'd0, 4'd0);
        tick();
        reset = 1'b0;
    endtask

    function automatic logic [XLEN-1:0] src_addr(input int src);
        case (src)
            1: return c_dc_addr;
            2: return c_ic_addr;
            3: return c_pf_addr;
            default: return '0;
        endcase
    endfunction

    // Single-cycle grant vectors; src: 0 none, 1 DC, 2 IC, 3 PF.
    typedef struct {
        logic [1:0] dcc, icc, pfc;
        logic [3:0] resp;
        logic [1:0] exp_cmd;
        int         exp_src;
        logic [3:0] exp_dr, exp_ir, exp_pr;
        logic       exp_gw;
    } vec_t;

    vec_t vecs[7];

    // Reference model state: owner 0 none, 1 DC, 2 IC, 3 PF.
    int m_owner[16];
    int m_pf_out, m_starve;
    bit m_err;

    task automatic model_reset();
        foreach (m_owner[i]) m_owner[i] = 0;
        m_pf_out = 0;
        m_starve = 0;
        m_err    = 1'b0;
    endtask

    // Compares the DUT against the rules for the current inputs, then advances the model.
    task automatic model_cycle();
        int gid, best, ic_rank, rt, rs, own, inc, dec;
        bit pf_ok, gw;
        logic [1:0] e_cmd;
        logic [XLEN-1:0] e_addr;
        rt = int'(mem2arb_tag);
        rs = int'(mem2arb_response);
        pf_ok = (pf_command != c_none) && (m_pf_out < 4);
        gid = 0; best = 99;
        if (dc_command != c_none) begin gid = 1; best = 0; end
        ic_rank = (m_starve >= 8) ? 3 : 1;
        if (ic_command != c_none && ic_rank < best) begin gid = 2; best = ic_rank; end
        if (pf_ok && 2 < best) begin gid = 3; best = 2; end
        e_cmd  = (gid == 1) ? dc_command : (gid == 2) ? ic_command : (gid == 3) ? pf_command : c_none;
        e_addr = (gid == 1) ? dc_addr : (gid == 2) ? ic_addr : (gid == 3) ? pf_addr : '0;
        gw = (pf_command != c_none) && (gid != 3 || rs == 0);
        own = (rt != 0) ? m_owner[rt] : 0;

        chk("rnd_cmd",  64'(arb2mem_command), 64'(e_cmd));
        chk("rnd_addr", 64'(arb2mem_addr), 64'(e_addr));
        chk("rnd_data", arb2mem_data, (gid == 1) ? dc_data : 64'd0);
        chk("rnd_dc_resp", 64'(dc_response), (gid == 1) ? 64'(rs) : 64'd0);
        chk("rnd_ic_resp", 64'(ic_response), (gid == 2) ? 64'(rs) : 64'd0);
        chk("rnd_pf_resp", 64'(pf_response), (gid == 3) ? 64'(rs) : 64'd0);
        chk("rnd_dc_tag", 64'(dc_tag), (own == 1) ? 64'(rt) : 64'd0);
        chk("rnd_ic_tag", 64'(ic_tag), (own == 2) ? 64'(rt) : 64'd0);
        chk("rnd_pf_tag", 64'(pf_tag), (own == 3) ? 64'(rt) : 64'd0);
        chk("rnd_give_way", 64'(pf_give_way), 64'(gw));
        chk("rnd_pf_out", 64'(pf_outstanding), 64'(m_pf_out));
        chk("rnd_tag_error", 64'(tag_error), 64'(m_err));

        if (reset) begin
            model_reset();
            return;
        end
        inc = 0; dec = 0;
        if (rt != 0) begin
            if (own != 0) begin
                m_owner[rt] = 0;
                if (own == 3) dec = 1;
            end else begin
                m_err = 1'b1;
            end
        end
        if (gid != 0 && rs != 0 && e_cmd == c_load) begin
            m_owner[rs] = gid;
            if (gid == 3) inc = 1;
        end
        m_pf_out = m_pf_out + inc - dec;
        if (m_pf_out > 4) m_pf_out = 4;
        if (m_pf_out < 0) m_pf_out = 0;
        if (pf_command == c_none || (gid == 3 && rs != 0)) m_starve = 0;
        else if (gw && pf_ok && m_starve < 8) m_starve = m_starve + 1;
    endtask

    initial begin
        int free_q[$];
        int own_q[$];
        int r, resp_v, tag_v;

        dc_addr = c_dc_addr; ic_addr = c_ic_addr; pf_addr = c_pf_addr; dc_data = c_dc_data;
        vecs[0] = '{c_none,  c_none, c_none, 4'd0, c_none,  0, 4'd0, 4'd0, 4'd0, 1'b0};
        vecs[1] = '{c_load,  c_load, c_none, 4'd5, c_load,  1, 4'd5, 4'd0, 4'd0, 1'b0};
        vecs[2] = '{c_none,  c_load, c_load, 4'd3, c_load,  2, 4'd0, 4'd3, 4'd0, 1'b1};
        vecs[3] = '{c_none,  c_none, c_load, 4'd2, c_load,  3, 4'd0, 4'd0, 4'd2, 1'b0};
        vecs[4] = '{c_none,  c_none, c_load, 4'd0, c_load,  3, 4'd0, 4'd0, 4'd0, 1'b1};
        vecs[5] = '{c_store, c_none, c_load, 4'd7, c_store, 1, 4'd7, 4'd0, 4'd0, 1'b1};
        vecs[6] = '{c_store, c_load, c_none, 4'd0, c_store, 1, 4'd0, 4'd0, 4'd0, 1'b0};

        // Reset held for the table so every vector sees the idle post-reset state.
        do_reset();
        reset = 1'b1;
        chk("reset_pf_out", 64'(pf_outstanding), 64'd0);
        chk("reset_tag_error", 64'(tag_error), 64'd0);
        chk("reset_cmd", 64'(arb2mem_command), 64'(c_none));
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].dcc, vecs[i].icc, vecs[i].pfc, vecs[i].resp, 4'd0);
            chk("vec_cmd", 64'(arb2mem_command), 64'(vecs[i].exp_cmd));
            chk("vec_addr", 64'(arb2mem_addr), 64'(src_addr(vecs[i].exp_src)));
            chk("vec_data", arb2mem_data, (vecs[i].exp_src == 1) ? c_dc_data : 64'd0);
            chk("vec_dc_resp", 64'(dc_response), 64'(vecs[i].exp_dr));
            chk("vec_ic_resp", 64'(ic_response), 64'(vecs[i].exp_ir));
            chk("vec_pf_resp", 64'(pf_response), 64'(vecs[i].exp_pr));
            chk("vec_give_way", 64'(pf_give_way), 64'(vecs[i].exp_gw));
            tick();
        end
        reset = 1'b0;

        // DC beats IC; returning tag routes to DC and clears the entry.
        do_reset();
        drive(c_load, c_load, c_none, 4'd5, 4'd0);
        chk("A_addr", 64'(arb2mem_addr), 64'(c_dc_addr));
        chk("A_dc_resp", 64'(dc_response), 64'd5);
        chk("A_ic_resp", 64'(ic_response), 64'd0);
        tick();
        drive(c_none, c_none, c_none, 4'd0, 4'd5);
        chk("A_dc_tag", 64'(dc_tag), 64'd5);
        chk("A_ic_tag", 64'(ic_tag), 64'd0);
        tick();
        drive(c_none, c_none, c_none, 4'd0, 4'd5);
        chk("A_cleared_dc_tag", 64'(dc_tag), 64'd0);
        tick();
        chk("A_cleared_err", 64'(tag_error), 64'd1);

        // Prefetch outstanding cap.
        do_reset();
        for (int t = 1; t <= 4; t++) begin
            drive(c_none, c_none, c_load, 4'(t), 4'd0);
            chk("B_pf_resp", 64'(pf_response), 64'(t));
            tick();
        end
        chk("B_pf_out_4", 64'(pf_outstanding), 64'd4);
        drive(c_none, c_none, c_load, 4'd6, 4'd0);
        chk("B_capped_cmd", 64'(arb2mem_command), 64'(c_none));
        chk("B_capped_gw", 64'(pf_give_way), 64'd1);
        chk("B_capped_resp", 64'(pf_response), 64'd0);
        tick();
        drive(c_none, c_none, c_none, 4'd0, 4'd2);
        chk("B_pf_tag", 64'(pf_tag), 64'd2);
        tick();
        chk("B_pf_out_3", 64'(pf_outstanding), 64'd3);

        // Starvation override.
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            drive(c_none, c_load, c_load, 4'd9, 4'd0);
            chk("C_denied_addr", 64'(arb2mem_addr), 64'(c_ic_addr));
            chk("C_denied_gw", 64'(pf_give_way), 64'd1);
            tick();
        end
        drive(c_none, c_load, c_load, 4'd9, 4'd0);
        chk("C_override_addr", 64'(arb2mem_addr), 64'(c_pf_addr));
        chk("C_override_pf_resp", 64'(pf_response), 64'd9);
        chk("C_override_ic_resp", 64'(ic_response), 64'd0);
        tick();
        drive(c_none, c_load, c_load, 4'd9, 4'd0);
        chk("C_after_addr", 64'(arb2mem_addr), 64'(c_ic_addr));
        tick();

        // Store allocates nothing; its returning tag is an orphan.
        do_reset();
        drive(c_store, c_none, c_none, 4'd7, 4'd0);
        chk("D_cmd", 64'(arb2mem_command), 64'(c_store));
        chk("D_dc_resp", 64'(dc_response), 64'd7);
        chk("D_data", arb2mem_data, c_dc_data);
        tick();
        drive(c_none, c_none, c_none, 4'd0, 4'd7);
        chk("D_tags", 64'({dc_tag, ic_tag, pf_tag}), 64'd0);
        tick();
        chk("D_err", 64'(tag_error), 64'd1);
        drive(c_none, c_none, c_none, 4'd0, 4'd0);
        tick();
        chk("D_err_sticky", 64'(tag_error), 64'd1);

        // Same-tag return and allocate.
        do_reset();
        drive(c_none, c_none, c_load, 4'd3, 4'd0);
        tick();
        chk("E_pf_out_1", 64'(pf_outstanding), 64'd1);
        drive(c_none, c_load, c_none, 4'd3, 4'd3);
        chk("E_pf_tag", 64'(pf_tag), 64'd3);
        chk("E_ic_tag", 64'(ic_tag), 64'd0);
        chk("E_ic_resp", 64'(ic_response), 64'd3);
        tick();
        chk("E_pf_out_0", 64'(pf_outstanding), 64'd0);
        drive(c_none, c_none, c_none, 4'd0, 4'd3);
        chk("E_new_owner", 64'(ic_tag), 64'd3);
        chk("E_new_owner_pf", 64'(pf_tag), 64'd0);
        tick();
        chk("E_no_err", 64'(tag_error), 64'd0);

        // Reset discards outstanding ownership.
        do_reset();
        drive(c_none, c_none, c_load, 4'd1, 4'd0);
        tick();
        drive(c_none, c_load, c_none, 4'd2, 4'd0);
        tick();
        chk("F_pf_out_pre", 64'(pf_outstanding), 64'd1);
        do_reset();
        drive(c_none, c_none, c_none, 4'd0, 4'd0);
        chk("F_cmd", 64'(arb2mem_command), 64'(c_none));
        chk("F_addr", 64'(arb2mem_addr), 64'd0);
        chk("F_resps", 64'({dc_response, ic_response, pf_response}), 64'd0);
        chk("F_pf_out", 64'(pf_outstanding), 64'd0);
        chk("F_err", 64'(tag_error), 64'd0);
        drive(c_none, c_none, c_none, 4'd0, 4'd1);
        chk("F_tags", 64'({dc_tag, ic_tag, pf_tag}), 64'd0);
        tick();
        chk("F_err_set", 64'(tag_error), 64'd1);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 9);
            dc_command = (r < 5) ? c_none : (r < 8) ? c_load : c_store;
            ic_command = ($urandom_range(0, 1) == 0) ? c_none : c_load;
            pf_command = ($urandom_range(0, 9) < 4) ? c_none : c_load;
            dc_addr = $urandom(); ic_addr = $urandom(); pf_addr = $urandom();
            dc_data = {$urandom(), $urandom()};
            free_q.delete();
            own_q.delete();
            for (int t = 1; t < 16; t++) begin
                if (m_owner[t] == 0) free_q.push_back(t);
                else own_q.push_back(t);
            end
            resp_v = 0;
            if ($urandom_range(0, 4) != 0 && free_q.size() > 0)
                resp_v = free_q[$urandom_range(0, free_q.size() - 1)];
            r = $urandom_range(0, 99);
            tag_v = 0;
            if (r < 40 && own_q.size() > 0) tag_v = own_q[$urandom_range(0, own_q.size() - 1)];
            else if (r >= 95) tag_v = $urandom_range(1, 15);
            mem2arb_response = 4'(resp_v);
            mem2arb_tag      = 4'(tag_v);
            #2;
            model_cycle();
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Arbitrates the single processor-memory port between three requesters: D-cache (ld/st), I-cache demand fetch, and I-prefetcher.
- Forwards the memory's same-cycle accept tag to the granted requester and keeps a tag-ownership table. When a data tag returns, it is routed to the requester that issued the load.
- Generates the give-way indication to the prefetcher and caps prefetch traffic with an outstanding-load limit and a starvation override.
- Sits between the cache/prefetch layer and the memory interface.

Parameters:
- NTAG, 16, tag space size. Tag 0 means invalid or rejected; tags 1..NTAG-1 are usable.
- PF_MAX_OUT, 4, maximum outstanding prefetch loads. Prefetch is masked once this is reached.
- STARVE_LIMIT, 8, consecutive denied prefetch cycles before prefetch outranks I-cache demand for one cycle.

Ports:
- clock  in  1  system clock
- reset  in  1  sync active-high reset
- dc_command  in  2  BUS_NONE/BUS_LOAD/BUS_STORE
- dc_addr  in  XLEN  D-cache address
- dc_data  in  64  store data
- ic_command  in  2  BUS_NONE/BUS_LOAD only
- ic_addr  in  XLEN  I-cache address
- pf_command  in  2  BUS_NONE/BUS_LOAD only
- pf_addr  in  XLEN  prefetch address
- mem2arb_response  in  4  same-cycle accept tag (0 = rejected)
- mem2arb_tag  in  4  returning data tag (0 = none)
- arb2mem_command  out  2  granted command
- arb2mem_addr  out  XLEN  granted address
- arb2mem_data  out  64  dc_data when DC granted, else 0
- dc_response, ic_response, pf_response  out  4 each  accept tag to granted requester, 0 otherwise
- dc_tag, ic_tag, pf_tag  out  4 each  returning tag, routed to its owner only
- pf_give_way  out  1  prefetch requested but not granted this cycle
- pf_outstanding  out  3  count of outstanding prefetch loads
- tag_error  out  1  sticky: a tag returned with no recorded owner

Behaviour:
- Reset (sync, active-high, on clock edge):
  - Ownership table all NONE; pf_outstanding=0; starve counter=0; tag_error=0.
  - Combinational outputs then evaluate to 0 / BUS_NONE when inputs are idle.
  - Reset mid-operation discards all outstanding ownership. Tags returning afterwards are dropped and set tag_error.
- Grant, combinational, same cycle:
  - Priority is DC > IC > PF.
  - PF is eligible only if pf_command!=BUS_NONE and pf_outstanding<PF_MAX_OUT.
  - Override: if starve==STARVE_LIMIT and DC is idle, PF beats IC.
  - The granted requester's command, addr and data drive arb2mem_*; with no grant, arb2mem_command=BUS_NONE and addr/data=0.
- Response forwarding:
  - mem2arb_response is copied to the granted requester's *_response port; the other response ports are 0.
  - Zero latency; a rejection (0) is passed through unchanged.
- pf_give_way = (pf_command!=BUS_NONE) & (PF not granted OR mem2arb_response==0).
- Ownership table: NTAG entries of 2 bits (NONE/DC/IC/PF), registered.
  - Accepted load (granted command==BUS_LOAD, response!=0): owner[response] <= granted id on the next edge.
  - Accepted store: no entry is allocated.
- Return routing:
  - If mem2arb_tag!=0 and owner[mem2arb_tag]!=NONE, drive the tag on that owner's *_tag port the same cycle (others 0) and clear the entry.
  - If the owner is NONE, drive no port and set tag_error (sticky until reset).
- Simultaneous events on one tag: if the returning tag equals the newly accepted tag in the same cycle, route the return using the old owner, then write the new owner. Allocate wins over clear.
- pf_outstanding:
  - +1 on an accepted PF load; -1 on a PF-owned tag return; unchanged if both occur.
  - Never exceeds PF_MAX_OUT and never goes below 0.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each cycle pf_give_way=1 with PF eligible.
  - Clears when PF is accepted, and when pf_command==BUS_NONE.
- Tag 0 on mem2arb_tag is always ignored.

Test Plan:
- DC load and IC load in the same cycle, response=5: arb2mem_addr=dc_addr, dc_response=5, ic_response=0. Later mem2arb_tag=5 gives dc_tag=5, ic_tag=0, and the entry clears.
- PF alone, 4 accepted loads (tags 1-4), no returns: pf_outstanding=4. A 5th pf_command sees arb2mem_command=BUS_NONE and pf_give_way=1. Returning tag 2 gives pf_tag=2 and pf_outstanding=3.
- IC and PF requesting continuously, DC idle: PF is denied 8 cycles, then granted in cycle 9. The counter clears on acceptance and IC wins again after.
- DC store accepted with response=7, then mem2arb_tag=7: no *_tag port driven, tag_error=1, and it stays 1.
- IC load accepted with tag 3 while mem2arb_tag=3 returns a PF-owned load in the same cycle: pf_tag=3 that cycle, owner[3]=IC next cycle, pf_outstanding decrements.
- Reset asserted with tags 1 and 2 outstanding: after reset all ports are 0 and pf_outstanding=0. A returning tag 1 sets tag_error.
